// File: rtl/rtc_bus_cycle_pkg.sv
// rtc_bus_cycle_pkg: shared state encoding, timing defaults and bus output bundle
// for the RTC multiplexed-bus sequencer.
package rtc_bus_cycle_pkg;

    localparam int CNT_W     = 8;
    localparam int T_SU_DEF  = 2;
    localparam int T_PW_DEF  = 10;
    localparam int T_HD_DEF  = 2;
    localparam int T_GAP_DEF = 4;

    // Encoding is sequential so every timed state advances to the next code.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A_SU  = 3'd1,
        S_A_STB = 3'd2,
        S_A_HD  = 3'd3,
        S_GAP   = 3'd4,
        S_D_STB = 3'd5,
        S_D_HD  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    typedef struct packed {
        logic [7:0] ad_out;
        logic       ad_oe;
        logic       ad_n;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       busy;
        logic       done;
    } bus_t;

    localparam bus_t BUS_RST = '{
        ad_out: 8'h00, ad_oe: 1'b0, ad_n: 1'b1, cs_n: 1'b1,
        rd_n: 1'b1, wr_n: 1'b1, busy: 1'b0, done: 1'b0
    };

endpackage

// File: rtl/rtc_bus_cycle_phase_timer.sv
// rtc_phase_timer: loadable 8-bit down counter; expire flags the last cycle of a phase.
module rtc_phase_timer
    import rtc_bus_cycle_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d    = load_i ? load_value_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    assign expire_o = cnt_q == CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: timed active-low address/data bus cycle generator for the RTC,
// with all bus outputs registered from the next state.
module rtc_bus_cycle
    import rtc_bus_cycle_pkg::*;
#(
    parameter int T_SU  = T_SU_DEF,
    parameter int T_PW  = T_PW_DEF,
    parameter int T_HD  = T_HD_DEF,
    parameter int T_GAP = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wr_nrd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_n,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    if (T_SU < 1 || T_SU > 255 || T_PW < 1 || T_PW > 255 ||
        T_HD < 1 || T_HD > 255 || T_GAP < 1 || T_GAP > 255) begin : g_bad_timing
        $error("rtc_bus_cycle: timing parameters must lie in 1..255");
    end

    state_t     s_q, s_d;
    bus_t       b_q, b_d;
    logic [7:0] a_q, a_d, w_q, w_d, rdata_q, rdata_d;
    logic       wr_q, wr_d, accept, expire;

    function automatic logic [CNT_W-1:0] dur(input state_t s);
        return (s == S_A_SU) ? CNT_W'(T_SU) :
               (s == S_A_STB || s == S_D_STB) ? CNT_W'(T_PW) :
               (s == S_A_HD || s == S_D_HD) ? CNT_W'(T_HD) :
               (s == S_GAP) ? CNT_W'(T_GAP) : CNT_W'(1);
    endfunction

    rtc_phase_timer u_timer (
        .clk_i       (clk),
        .rst_ni      (rst),
        .load_i      (s_d != s_q),
        .load_value_i(dur(s_d)),
        .expire_o    (expire)
    );

    assign accept  = s_q == S_IDLE && req;
    assign a_d     = accept ? addr : a_q;
    assign w_d     = accept ? wdata : w_q;
    assign wr_d    = accept ? wr_nrd : wr_q;
    assign rdata_d = (s_q == S_D_STB && expire && !wr_q) ? ad_in : rdata_q;

    always_comb begin
        s_d = s_q;
        if (s_q == S_IDLE)      s_d = req ? S_A_SU : S_IDLE;
        else if (s_q == S_DONE) s_d = S_IDLE;
        else if (expire)        s_d = state_t'(s_q + 3'd1);
    end

    // Outputs are computed from the next state so they change on the same edge as the state.
    always_comb begin
        b_d        = BUS_RST;
        b_d.busy   = s_d != S_IDLE;
        b_d.done   = s_d == S_DONE;
        b_d.ad_n   = !(s_d inside {S_A_SU, S_A_STB, S_A_HD});
        b_d.cs_n   = !(s_d inside {S_A_STB, S_D_STB});
        b_d.wr_n   = !(s_d == S_A_STB || (s_d == S_D_STB && wr_d));
        b_d.rd_n   = !(s_d == S_D_STB && !wr_d);
        b_d.ad_oe  = !b_d.ad_n || (wr_d && s_d inside {S_GAP, S_D_STB, S_D_HD});
        b_d.ad_out = !b_d.ad_n ? a_d : (b_d.ad_oe ? w_d : 8'h00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q     <= S_IDLE;
            b_q     <= BUS_RST;
            a_q     <= '0;
            w_q     <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            s_q     <= s_d;
            b_q     <= b_d;
            a_q     <= a_d;
            w_q     <= w_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign ad_out = b_q.ad_out;
    assign ad_oe  = b_q.ad_oe;
    assign ad_n   = b_q.ad_n;
    assign cs_n   = b_q.cs_n;
    assign rd_n   = b_q.rd_n;
    assign wr_n   = b_q.wr_n;
    assign busy   = b_q.busy;
    assign done   = b_q.done;
    assign rdata  = rdata_q;

endmodule
